// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, FSM states
// and the counter-width helper.
package mdu_pkg;

  typedef enum logic [1:0] {
    OP_MULTU = 2'b00,
    OP_DIVU  = 2'b01,
    OP_MULT  = 2'b10,
    OP_DIV   = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_e;

  // Bits needed to count 0..value-1 (at least one bit).
  function automatic int clog2(input int unsigned value);
    int r;
    r = 1;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((32'd1 << i) < value) r = int'(i) + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// Operand/result bundle between the decode/register-file side and the MDU.
interface mult_div_unit_if #(parameter int DATA = 32);
  logic            start;
  logic [1:0]      op;
  logic [DATA-1:0] A;
  logic [DATA-1:0] B;
  logic            hi_we;
  logic            lo_we;
  logic [DATA-1:0] WD;
  logic            busy;
  logic            done;
  logic            div_by_zero;
  logic [DATA-1:0] HI;
  logic [DATA-1:0] LO;

  modport master (
    output start, op, A, B, hi_we, lo_we, WD,
    input  busy, done, div_by_zero, HI, LO
  );

  modport slave (
    input  start, op, A, B, hi_we, lo_we, WD,
    output busy, done, div_by_zero, HI, LO
  );
endinterface

// File: rtl/mdu_iter_core.sv
// One iteration of the MDU datapath: shift-add multiply step or restoring
// divide step, computed combinationally on the {acc, q} pair.
module mdu_iter_core #(
  parameter int DATA = 32
) (
  input  logic            div_mode,
  input  logic [DATA-1:0] m,
  input  logic [DATA-1:0] acc_i,
  input  logic [DATA-1:0] q_i,
  output logic [DATA-1:0] acc_o,
  output logic [DATA-1:0] q_o
);

  logic [DATA:0] sum;
  logic [DATA:0] shifted;
  logic [DATA:0] diff;

  // Next {acc, q}: multiply shifts right after a conditional add, divide
  // shifts left and keeps the trial subtraction when it does not borrow.
  always_comb begin
    sum     = {1'b0, acc_i} + {1'b0, m};
    shifted = {acc_i, q_i[DATA-1]};
    diff    = shifted - {1'b0, m};
    if (div_mode) begin
      if (!diff[DATA]) begin
        acc_o = diff[DATA-1:0];
        q_o   = {q_i[DATA-2:0], 1'b1};
      end else begin
        acc_o = shifted[DATA-1:0];
        q_o   = {q_i[DATA-2:0], 1'b0};
      end
    end else if (q_i[0]) begin
      acc_o = sum[DATA:1];
      q_o   = {sum[0], q_i[DATA-1:1]};
    end else begin
      acc_o = {1'b0, acc_i[DATA-1:1]};
      q_o   = {acc_i[0], q_i[DATA-1:1]};
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit with HI/LO result registers.
// Optional feature macro: MULT_DIV_SIGNED_EN (signed MULT/DIV via op[1]).
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int DATA = 32
) (
  input  logic           clk,
  input  logic           rstn,
  mult_div_unit_if.slave mdu
);

  localparam int             CW       = clog2(DATA);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DATA - 1);

  state_e          state;
  logic [CW-1:0]   cnt;
  logic [DATA-1:0] acc, q, m;
  logic [DATA-1:0] acc_n, q_n;
  logic            div_mode;
  logic            start_div;
  logic [DATA-1:0] a_mag, b_mag;
  logic [DATA-1:0] res_hi, res_lo;
  logic            busy_r, done_r, dbz_r;
  logic [DATA-1:0] hi_r, lo_r;

  assign start_div = (mdu.op == OP_DIVU) || (mdu.op == OP_DIV);

  mdu_iter_core #(.DATA(DATA)) u_core (
    .div_mode (div_mode),
    .m        (m),
    .acc_i    (acc),
    .q_i      (q),
    .acc_o    (acc_n),
    .q_o      (q_n)
  );

`ifdef MULT_DIV_SIGNED_EN
  logic a_neg, b_neg;
  logic neg_lo, neg_hi;

  // Operand magnitudes and sign fix-up of the final iteration result.
  always_comb begin
    a_neg = mdu.op[1] & mdu.A[DATA-1];
    b_neg = mdu.op[1] & mdu.B[DATA-1];
    a_mag = a_neg ? -mdu.A : mdu.A;
    b_mag = b_neg ? -mdu.B : mdu.B;
    if (div_mode) begin
      res_lo = neg_lo ? -q_n : q_n;
      res_hi = neg_hi ? -acc_n : acc_n;
    end else begin
      {res_hi, res_lo} = neg_lo ? -{acc_n, q_n} : {acc_n, q_n};
    end
  end

  // Result signs captured at launch: quotient/product = A^B, remainder = A.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      neg_lo <= 1'b0;
      neg_hi <= 1'b0;
    end else if (state == S_IDLE && mdu.start) begin
      neg_lo <= a_neg ^ b_neg;
      neg_hi <= start_div ? a_neg : (a_neg ^ b_neg);
    end
  end
`else
  // Unsigned only: operands and results pass straight through.
  always_comb begin
    a_mag  = mdu.A;
    b_mag  = mdu.B;
    res_hi = acc_n;
    res_lo = q_n;
  end
`endif

  // Control FSM, iteration registers and HI/LO with registered status outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= S_IDLE;
      cnt      <= '0;
      acc      <= '0;
      q        <= '0;
      m        <= '0;
      div_mode <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      dbz_r    <= 1'b0;
      hi_r     <= '0;
      lo_r     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          done_r <= 1'b0;
          dbz_r  <= 1'b0;
          if (mdu.start) begin
            div_mode <= start_div;
            if (start_div && mdu.B == '0) begin
              state  <= S_DONE;
              hi_r   <= mdu.A;
              lo_r   <= '1;
              dbz_r  <= 1'b1;
              done_r <= 1'b1;
            end else begin
              state  <= S_RUN;
              busy_r <= 1'b1;
              cnt    <= '0;
              acc    <= '0;
              m      <= start_div ? b_mag : a_mag;
              q      <= start_div ? a_mag : b_mag;
            end
          end else begin
            if (mdu.hi_we) hi_r <= mdu.WD;
            if (mdu.lo_we) lo_r <= mdu.WD;
          end
        end
        S_RUN: begin
          acc <= acc_n;
          q   <= q_n;
          cnt <= cnt + 1'b1;
          if (cnt == CNT_LAST) begin
            state  <= S_DONE;
            busy_r <= 1'b0;
            done_r <= 1'b1;
            hi_r   <= res_hi;
            lo_r   <= res_lo;
          end
        end
        default: begin
          state  <= S_IDLE;
          done_r <= 1'b0;
          dbz_r  <= 1'b0;
          busy_r <= 1'b0;
        end
      endcase
    end
  end

  assign mdu.busy        = busy_r;
  assign mdu.done        = done_r;
  assign mdu.div_by_zero = dbz_r;
  assign mdu.HI          = hi_r;
  assign mdu.LO          = lo_r;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit (DATA=32): directed table, hand
// sequences for multi-cycle corner cases, and randomized ops against a model.
module tb_mult_div_unit;

  logic clk;
  logic rstn;
  int   n_chk;
  int   n_fail;

  mult_div_unit_if #(.DATA(32)) mif ();

  mult_div_unit #(.DATA(32)) dut (
    .clk  (clk),
    .rstn (rstn),
    .mdu  (mif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
  } vec_t;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
  } res_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain 64-bit arithmetic from the operation definitions.
  function automatic res_t model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    res_t   r;
    bit     sgn;
    longint sa, sb, p, qq, rr;
    sgn = 1'b0;
`ifdef MULT_DIV_SIGNED_EN
    sgn = o[1];
`endif
    sa = sgn ? longint'($signed(a)) : longint'({32'd0, a});
    sb = sgn ? longint'($signed(b)) : longint'({32'd0, b});
    r.dbz = 1'b0;
    if (!o[0]) begin
      p    = sa * sb;
      r.hi = p[63:32];
      r.lo = p[31:0];
    end else if (b == 32'd0) begin
      r.hi  = a;
      r.lo  = 32'hFFFF_FFFF;
      r.dbz = 1'b1;
    end else begin
      qq   = sa / sb;
      rr   = sa % sb;
      r.lo = qq[31:0];
      r.hi = rr[31:0];
    end
    return r;
  endfunction

  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] hi, output logic [31:0] lo, output logic dbz,
                        output int lat, output int bcnt);
    mif.start = 1'b1;
    mif.op    = o;
    mif.A     = a;
    mif.B     = b;
    tick();
    mif.start = 1'b0;
    lat = -1; bcnt = 0; hi = '0; lo = '0; dbz = 1'b0;
    for (int n = 1; n <= 100; n++) begin
      if (mif.done) begin
        lat = n; hi = mif.HI; lo = mif.LO; dbz = mif.div_by_zero;
        break;
      end
      if (mif.busy) bcnt++;
      tick();
    end
  endtask

  task automatic check_op(input string nm, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input res_t e);
    logic [31:0] hi, lo;
    logic        dbz;
    int          lat, bcnt, exp_lat;
    exp_lat = (o[0] && b == 32'd0) ? 1 : 33;
    run_op(o, a, b, hi, lo, dbz, lat, bcnt);
    chk({nm, ".latency"}, 64'(lat), 64'(exp_lat));
    chk({nm, ".busy_cycles"}, 64'(bcnt), 64'(exp_lat - 1));
    chk({nm, ".HI"}, 64'(hi), 64'(e.hi));
    chk({nm, ".LO"}, 64'(lo), 64'(e.lo));
    chk({nm, ".div_by_zero"}, 64'(dbz), 64'(e.dbz));
    tick();
    chk({nm, ".done_one_cycle"}, 64'(mif.done), 64'd0);
    chk({nm, ".dbz_cleared"}, 64'(mif.div_by_zero), 64'd0);
  endtask

  task automatic write_hl(input logic hw, input logic lw, input logic [31:0] wd);
    mif.hi_we = hw;
    mif.lo_we = lw;
    mif.WD    = wd;
    tick();
    mif.hi_we = 1'b0;
    mif.lo_we = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int ok;
    ok = 0;
    for (int n = 0; n < 100; n++) begin
      if (mif.done) begin ok = 1; break; end
      tick();
    end
    chk({nm, ".done_seen"}, 64'(ok), 64'd1);
  endtask

  vec_t tbl[6];
  res_t e;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk = 0; n_fail = 0;
    rstn = 1'b0;
    mif.start = 1'b0; mif.op = 2'b00; mif.A = '0; mif.B = '0;
    mif.hi_we = 1'b0; mif.lo_we = 1'b0; mif.WD = '0;
    repeat (3) tick();
    chk("reset.HI", 64'(mif.HI), 64'd0);
    chk("reset.LO", 64'(mif.LO), 64'd0);
    chk("reset.busy", 64'(mif.busy), 64'd0);
    chk("reset.done", 64'(mif.done), 64'd0);
    chk("reset.dbz", 64'(mif.div_by_zero), 64'd0);
    rstn = 1'b1;
    tick();

    // Directed vectors with hand-derived results.
    tbl[0] = '{"multu_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
    tbl[1] = '{"divu_100_7", 2'b01, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0};
    tbl[2] = '{"divu_by_zero", 2'b01, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b1};
`ifdef MULT_DIV_SIGNED_EN
    tbl[3] = '{"div_m7_2", 2'b11, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
    tbl[4] = '{"mult_m3_5", 2'b10, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0};
    tbl[5] = '{"div_minneg_m1", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0};
`else
    tbl[3] = '{"div_m7_2", 2'b11, 32'hFFFF_FFF9, 32'd2, 32'h0000_0001, 32'h7FFF_FFFC, 1'b0};
    tbl[4] = '{"mult_m3_5", 2'b10, 32'hFFFF_FFFD, 32'd5, 32'h0000_0004, 32'hFFFF_FFF1, 1'b0};
    tbl[5] = '{"div_minneg_m1", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0, 1'b0};
`endif
    for (int i = 0; i < 6; i++) begin
      e.hi = tbl[i].hi; e.lo = tbl[i].lo; e.dbz = tbl[i].dbz;
      check_op(tbl[i].nm, tbl[i].op, tbl[i].a, tbl[i].b, e);
    end

    // MTHI / MTLO in IDLE, individually and together.
    write_hl(1'b1, 1'b0, 32'hDEAD_BEEF);
    chk("mthi.HI", 64'(mif.HI), 64'hDEAD_BEEF);
    write_hl(1'b0, 1'b1, 32'h1234_5678);
    chk("mtlo.LO", 64'(mif.LO), 64'h1234_5678);
    chk("mtlo.HI_kept", 64'(mif.HI), 64'hDEAD_BEEF);
    write_hl(1'b1, 1'b1, 32'hA5A5_A5A5);
    chk("mt_both.HI", 64'(mif.HI), 64'hA5A5_A5A5);
    chk("mt_both.LO", 64'(mif.LO), 64'hA5A5_A5A5);

    // Writes while running are ignored; result lands at completion.
    write_hl(1'b1, 1'b0, 32'hDEAD_BEEF);
    write_hl(1'b0, 1'b1, 32'h1234_5678);
    mif.start = 1'b1; mif.op = 2'b00; mif.A = 32'd3; mif.B = 32'd4;
    tick();
    mif.start = 1'b0;
    tick();
    write_hl(1'b1, 1'b1, 32'h0BAD_F00D);
    chk("run_write.busy", 64'(mif.busy), 64'd1);
    chk("run_write.HI", 64'(mif.HI), 64'hDEAD_BEEF);
    chk("run_write.LO", 64'(mif.LO), 64'h1234_5678);
    wait_done("run_write");
    chk("run_write.result_HI", 64'(mif.HI), 64'd0);
    chk("run_write.result_LO", 64'(mif.LO), 64'd12);
    tick();

    // Second start pulse mid-operation is ignored.
    begin
      int dcnt, dcyc;
      dcnt = 0; dcyc = -1;
      mif.start = 1'b1; mif.op = 2'b00; mif.A = 32'd7; mif.B = 32'd9;
      tick();
      mif.start = 1'b0;
      for (int c = 1; c <= 45; c++) begin
        if (mif.done) begin dcnt++; if (dcyc < 0) dcyc = c; end
        mif.start = (c == 4);
        if (c == 4) begin mif.op = 2'b01; mif.A = 32'd1; mif.B = 32'd0; end
        if (c == 33) chk("repulse.LO", 64'(mif.LO), 64'd63);
        tick();
      end
      chk("repulse.done_count", 64'(dcnt), 64'd1);
      chk("repulse.done_cycle", 64'(dcyc), 64'd33);
      chk("repulse.dbz", 64'(mif.div_by_zero), 64'd0);
    end

    // start and hi_we together: start wins, WD dropped.
    write_hl(1'b1, 1'b0, 32'h1111_1111);
    mif.start = 1'b1; mif.op = 2'b00; mif.A = 32'd2; mif.B = 32'd3;
    mif.hi_we = 1'b1; mif.WD = 32'h5555_5555;
    tick();
    mif.start = 1'b0; mif.hi_we = 1'b0;
    chk("start_hiwe.HI", 64'(mif.HI), 64'h1111_1111);
    chk("start_hiwe.busy", 64'(mif.busy), 64'd1);
    wait_done("start_hiwe");
    chk("start_hiwe.result_LO", 64'(mif.LO), 64'd6);
    tick();

    // Reset mid-divide aborts; a following op runs normally.
    write_hl(1'b1, 1'b1, 32'hCAFE_0001);
    mif.start = 1'b1; mif.op = 2'b01; mif.A = 32'd1000; mif.B = 32'd3;
    tick();
    mif.start = 1'b0;
    repeat (9) tick();
    rstn = 1'b0;
    #1;
    chk("midrst.HI", 64'(mif.HI), 64'd0);
    chk("midrst.LO", 64'(mif.LO), 64'd0);
    chk("midrst.busy", 64'(mif.busy), 64'd0);
    repeat (2) tick();
    rstn = 1'b1;
    begin
      int dcnt;
      dcnt = 0;
      for (int c = 0; c < 40; c++) begin
        if (mif.done) dcnt++;
        tick();
      end
      chk("midrst.no_done", 64'(dcnt), 64'd0);
    end
    e.hi = 32'd1; e.lo = 32'd333; e.dbz = 1'b0;
    check_op("after_rst_divu", 2'b01, 32'd1000, 32'd3, e);

    // Randomized operations against the reference model.
    for (int i = 0; i < 40; i++) begin
      logic [1:0]  o;
      logic [31:0] a, b;
      int          sel;
      o   = 2'($urandom_range(0, 3));
      a   = $urandom;
      sel = $urandom_range(0, 7);
      if (sel == 0)      b = 32'd0;
      else if (sel < 3)  b = $urandom_range(1, 15);
      else if (sel == 3) b = 32'hFFFF_FFFF;
      else               b = $urandom;
      if ($urandom_range(0, 9) == 0) a = 32'h8000_0000;
      e = model(o, a, b);
      check_op($sformatf("rand%0d", i), o, a, b, e);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
